// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: byte-level I2C master sequencer driving SCL/SDA and an external 8-bit shift register
module i2c_byte_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       done,
    output logic       err,
    output logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       scl_oe,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       sr_load,
    output logic [7:0] sr_ins,
    output logic       sr_shift,
    output logic       sr_in_shift,
    output logic       sr_inb,
    input  logic [7:0] sr_out
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PRE = CW'(CLK_DIV - 2);

    typedef enum logic [2:0] {IDLE, START, BITS, ACK, STOP, FIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    q;
    logic [1:0]    nq;
    logic [2:0]    bit_idx;
    logic          owned;
    logic          rd;
    logic          ack_l;
    logic          last;
    logic          stall;
    logic          active;
    logic          adv;
    logic          sample;

    assign active      = state inside {START, BITS, ACK, STOP};
    assign last        = cnt == LAST;
    assign stall       = q == 2'd2 && !scl_in;
    assign adv         = active && last && !stall;
    assign sample      = adv && q == 2'd2;
    assign nq          = q + 2'd1;
    assign cmd_ready   = state == IDLE;
    assign busy        = state != IDLE;
    assign sr_in_shift = state == BITS && rd && sample;
    assign sr_inb      = sr_in_shift && sda_in;

    // Sequencer: quarter timing, bus drive, shift-register control and command completion
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            q        <= 2'd0;
            bit_idx  <= 3'd0;
            owned    <= 1'b0;
            rd       <= 1'b0;
            ack_l    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rx_ack   <= 1'b0;
            rx_data  <= 8'h00;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            sr_load  <= 1'b0;
            sr_ins   <= 8'h00;
            sr_shift <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            sr_load  <= 1'b0;
            sr_shift <= state == BITS && !rd && q == 2'd3 && cnt == PRE && bit_idx != 3'd7;
            if (active && !stall) cnt <= last ? '0 : cnt + 1'b1;
            if (adv) q <= nq;
            if (state == ACK && !rd && sample) rx_ack <= sda_in;
            if (adv && q != 2'd3) begin
                scl_oe <= state == START ? nq == 2'd3 : state == STOP ? 1'b0 : nq == 2'd1;
                if (state == START) sda_oe <= nq[1];
                if (state == STOP) sda_oe <= nq == 2'd1;
            end
            case (state)
                IDLE: if (cmd_valid) begin
                    cnt     <= '0;
                    q       <= 2'd0;
                    bit_idx <= 3'd0;
                    rd      <= cmd == 2'b10;
                    ack_l   <= cmd_ack;
                    sr_ins  <= cmd_data;
                    if (cmd == 2'b00) begin
                        state  <= START;
                        scl_oe <= 1'b1;
                        sda_oe <= 1'b0;
                    end else if (!owned) begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (cmd == 2'b11) begin
                        state  <= STOP;
                        scl_oe <= 1'b1;
                        sda_oe <= 1'b1;
                    end else begin
                        state   <= BITS;
                        sr_load <= !cmd[1];
                        sda_oe  <= !cmd[1] && !cmd_data[7];
                    end
                end
                START: if (adv && q == 2'd3) begin
                    state <= FIN;
                    done  <= 1'b1;
                    owned <= 1'b1;
                end
                BITS: if (adv && q == 2'd3) begin
                    scl_oe <= 1'b1;
                    if (bit_idx == 3'd7) begin
                        state  <= ACK;
                        sda_oe <= rd && !ack_l;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        sda_oe  <= !rd && !sr_out[6];
                    end
                end
                ACK: if (adv && q == 2'd3) begin
                    state  <= FIN;
                    done   <= 1'b1;
                    scl_oe <= 1'b1;
                    if (rd) rx_data <= sr_out;
                end
                STOP: if (adv && q == 2'd3) begin
                    state <= FIN;
                    done  <= 1'b1;
                    owned <= 1'b0;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
